// File: rtl/inst_mem_controller.sv
// rtl/inst_mem_controller.sv - boot-time word loader and run-time fetch sequencer for a byte-wide instruction memory
module inst_mem_controller #(
    parameter int MEM_BYTES = 1024,
    parameter int BYTE_AW   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [63:0]        load_addr,
    input  logic [31:0]        load_data,
    input  logic               load_done,
    input  logic               reload,
    input  logic               fetch_req,
    input  logic [63:0]        fetch_addr,
    output logic               fetch_valid,
    output logic [31:0]        fetch_inst,
    output logic               stall,
    output logic               mem_we,
    output logic [BYTE_AW-1:0] mem_waddr,
    output logic [7:0]         mem_wdata,
    output logic [63:0]        mem_raddr,
    input  logic [31:0]        mem_rdata,
    output logic [15:0]        words_loaded,
    output logic               error
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    // A word at address a fits when a + 3 < MEM_BYTES, i.e. a < MEM_BYTES - 3.
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 3);

    state_t               state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic [BYTE_AW-1:2]   addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 mem_we_q, mem_we_d;
    logic [BYTE_AW-1:0]   mem_waddr_q, mem_waddr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [31:0]          fetch_inst_q, fetch_inst_d;
    logic [15:0]          words_q, words_d;
    logic                 error_q, error_d;

    logic load_good;
    logic fetch_good;

    assign load_good  = (load_addr[1:0] == 2'b00) && (load_addr < ADDR_LIMIT);
    assign fetch_good = (fetch_addr[1:0] == 2'b00) && (fetch_addr < ADDR_LIMIT);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mem_we_d      = 1'b0;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        fetch_valid_d = 1'b0;
        fetch_inst_d  = fetch_inst_q;
        words_d       = words_q;
        error_d       = error_q;

        case (state_q)
            BOOT: begin
                if (load_valid) begin
                    if (load_good) begin
                        // Byte 0 is staged on the transfer edge so the memory sees it one edge later.
                        addr_d      = load_addr[BYTE_AW-1:2];
                        data_d      = load_data;
                        k_d         = 2'd0;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = load_addr[BYTE_AW-1:0];
                        mem_wdata_d = load_data[7:0];
                        state_d     = WRITE;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (load_done) begin
                    state_d = RUN;
                end
            end

            WRITE: begin
                if (k_q == 2'd3) begin
                    state_d = BOOT;
                    if (words_q != 16'hFFFF) begin
                        words_d = words_q + 16'd1;
                    end
                end else begin
                    k_d         = k_q + 2'd1;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = {addr_q, k_d};
                    mem_wdata_d = data_q[{k_d, 3'b000} +: 8];
                end
            end

            RUN: begin
                if (reload) begin
                    state_d = BOOT;
                    words_d = 16'd0;
                end else if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    if (fetch_good) begin
                        fetch_inst_d = mem_rdata;
                    end else begin
                        fetch_inst_d = NOP_INST;
                        error_d      = 1'b1;
                    end
                end
            end

            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            k_q           <= 2'd0;
            addr_q        <= '0;
            data_q        <= 32'd0;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= 8'd0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= 32'd0;
            words_q       <= 16'd0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mem_we_q      <= mem_we_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            words_q       <= words_d;
            error_q       <= error_d;
        end
    end

    assign load_ready   = (state_q == BOOT);
    assign stall        = (state_q != RUN);
    assign mem_raddr    = fetch_addr;
    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_inst   = fetch_inst_q;
    assign words_loaded = words_q;
    assign error        = error_q;

endmodule
